// File: rtl/ara_jtag_tb_pkg.sv
// Shared types and constants for the JTAG-reachable simulation harness: TAP states,
// IR codes, MEMACC data-register layout and the harness register map.
package ara_jtag_tb_pkg;

    typedef enum logic [3:0] {
        StTestLogicReset,
        StRunTestIdle,
        StSelectDrScan,
        StCaptureDr,
        StShiftDr,
        StExit1Dr,
        StPauseDr,
        StExit2Dr,
        StUpdateDr,
        StSelectIrScan,
        StCaptureIr,
        StShiftIr,
        StExit1Ir,
        StPauseIr,
        StExit2Ir,
        StUpdateIr
    } tap_state_e;

    typedef enum logic [4:0] {
        IrIdcode = 5'h01,
        IrMemacc = 5'h10,
        IrBypass = 5'h1F
    } ir_e;

    typedef enum logic [1:0] {
        OpNop   = 2'd0,
        OpRead  = 2'd1,
        OpWrite = 2'd2,
        OpNop3  = 2'd3
    } memacc_op_e;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [1:0]  op;
    } memacc_dr_t;

    localparam int unsigned IrWidth    = 5;
    localparam int unsigned DrWidth    = $bits(memacc_dr_t);
    localparam logic [4:0]  IrCapture  = 5'b00001;
    localparam logic [31:0] IdcodeValue = 32'h1A4A_0DB3;

    localparam logic [7:0] AddrTohost   = 8'h00;
    localparam logic [7:0] AddrCyclesLo = 8'h01;
    localparam logic [7:0] AddrCyclesHi = 8'h02;
    localparam logic [7:0] AddrInfo     = 8'h03;
    localparam logic [3:0] ScratchPage  = 4'h1;

    localparam logic [1:0] StatusOk       = 2'd0;
    localparam logic [1:0] StatusUnmapped = 2'd2;

endpackage

// File: rtl/ara_jtag_test_harness_if.sv
// Four-wire JTAG bundle; the driver side is the master, the TAP side is the slave.
interface ara_jtag_test_harness_if;
    logic tck;
    logic trst_n;
    logic tms;
    logic tdi;
    logic tdo;

    modport master (output tck, trst_n, tms, tdi, input tdo);
    modport slave  (input tck, trst_n, tms, tdi, output tdo);
endinterface

// File: rtl/ara_jtag_tap.sv
// JTAG TAP running entirely on clk_i: input synchronizers, IEEE 1149.1 state machine,
// IR and the IDCODE/MEMACC/BYPASS data registers, plus the MEMACC update strobe.
module ara_jtag_tap
    import ara_jtag_tb_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rst_ni,
    ara_jtag_test_harness_if.slave        jtag,
    output logic                          update_o,
    output logic [7:0]                    addr_o,
    output memacc_op_e                    op_o,
    output logic [31:0]                   wdata_o,
    input  logic [31:0]                   rdata_i,
    input  logic [1:0]                    status_i
);

    tap_state_e           state_q, state_d;
    logic [3:0]           sync1_q, sync1_d, sync2_q, sync2_d;
    logic                 tck_prev_q, tck_prev_d;
    logic [IrWidth-1:0]   ir_q, ir_d, ir_sr_q, ir_sr_d;
    logic [DrWidth-1:0]   dr_sr_q, dr_sr_d;
    logic [7:0]           last_addr_q, last_addr_d;
    logic                 tdo_q, tdo_d;
    logic                 upd_q, upd_d;
    logic                 tck_s, trst_s, tms_s, tdi_s, tck_rise, tck_fall;
    memacc_dr_t           dr_view;

    // Bit order {tck, trst_n, tms, tdi}; all four share the same latency so they stay aligned.
    always_comb begin
        sync1_d    = {jtag.tck, jtag.trst_n, jtag.tms, jtag.tdi};
        sync2_d    = sync1_q;
        tck_prev_d = sync2_q[3];
    end

    assign {tck_s, trst_s, tms_s, tdi_s} = sync2_q;
    assign tck_rise = tck_s & ~tck_prev_q;
    assign tck_fall = ~tck_s & tck_prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StTestLogicReset;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!trst_s) begin
            state_d = StTestLogicReset;
        end else if (tck_rise) begin
            case (state_q)
                StTestLogicReset: state_d = tms_s ? StTestLogicReset : StRunTestIdle;
                StRunTestIdle:    state_d = tms_s ? StSelectDrScan : StRunTestIdle;
                StSelectDrScan:   state_d = tms_s ? StSelectIrScan : StCaptureDr;
                StCaptureDr:      state_d = tms_s ? StExit1Dr : StShiftDr;
                StShiftDr:        state_d = tms_s ? StExit1Dr : StShiftDr;
                StExit1Dr:        state_d = tms_s ? StUpdateDr : StPauseDr;
                StPauseDr:        state_d = tms_s ? StExit2Dr : StPauseDr;
                StExit2Dr:        state_d = tms_s ? StUpdateDr : StShiftDr;
                StUpdateDr:       state_d = tms_s ? StSelectDrScan : StRunTestIdle;
                StSelectIrScan:   state_d = tms_s ? StTestLogicReset : StCaptureIr;
                StCaptureIr:      state_d = tms_s ? StExit1Ir : StShiftIr;
                StShiftIr:        state_d = tms_s ? StExit1Ir : StShiftIr;
                StExit1Ir:        state_d = tms_s ? StUpdateIr : StPauseIr;
                StPauseIr:        state_d = tms_s ? StExit2Ir : StPauseIr;
                StExit2Ir:        state_d = tms_s ? StUpdateIr : StShiftIr;
                StUpdateIr:       state_d = tms_s ? StSelectDrScan : StRunTestIdle;
                default:          state_d = StTestLogicReset;
            endcase
        end
    end

    always_comb begin
        ir_d        = ir_q;
        ir_sr_d     = ir_sr_q;
        dr_sr_d     = dr_sr_q;
        last_addr_d = last_addr_q;
        tdo_d       = tdo_q;
        upd_d       = 1'b0;
        if (tck_rise) begin
            case (state_q)
                StCaptureIr: ir_sr_d = IrCapture;
                StShiftIr:   ir_sr_d = {tdi_s, ir_sr_q[IrWidth-1:1]};
                StCaptureDr: begin
                    case (ir_q)
                        IrIdcode: dr_sr_d = {10'b0, IdcodeValue};
                        IrMemacc: dr_sr_d = {last_addr_q, rdata_i, status_i};
                        default:  dr_sr_d = '0;
                    endcase
                end
                StShiftDr: begin
                    // TDI enters at the MSB of whichever register the IR selects.
                    case (ir_q)
                        IrIdcode: dr_sr_d = {10'b0, tdi_s, dr_sr_q[31:1]};
                        IrMemacc: dr_sr_d = {tdi_s, dr_sr_q[DrWidth-1:1]};
                        default:  dr_sr_d = {{(DrWidth-1){1'b0}}, tdi_s};
                    endcase
                end
                default: ;
            endcase
            if (state_d == StUpdateIr) ir_d = ir_sr_q;
            if (state_d == StUpdateDr && ir_q == IrMemacc) upd_d = 1'b1;
        end
        if (tck_fall) begin
            if (state_q == StShiftDr) begin
                tdo_d = dr_sr_q[0];
            end else if (state_q == StShiftIr) begin
                tdo_d = ir_sr_q[0];
            end
        end
        if (state_d == StTestLogicReset) ir_d = IrIdcode;
        if (upd_q && (dr_view.op == OpRead || dr_view.op == OpWrite)) last_addr_d = dr_view.addr;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            tck_prev_q  <= 1'b0;
            ir_q        <= IrIdcode;
            ir_sr_q     <= '0;
            dr_sr_q     <= '0;
            last_addr_q <= '0;
            tdo_q       <= 1'b0;
            upd_q       <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            tck_prev_q  <= tck_prev_d;
            ir_q        <= ir_d;
            ir_sr_q     <= ir_sr_d;
            dr_sr_q     <= dr_sr_d;
            last_addr_q <= last_addr_d;
            tdo_q       <= tdo_d;
            upd_q       <= upd_d;
        end
    end

    assign dr_view  = dr_sr_q;
    assign update_o = upd_q;
    assign addr_o   = dr_view.addr;
    assign op_o     = memacc_op_e'(dr_view.op);
    assign wdata_o  = dr_view.data;
    assign jtag.tdo = tdo_q;

endmodule

// File: rtl/ara_jtag_test_harness.sv
// JTAG-only simulation harness: tohost/exit register, runtime counter, info word, scratchpad.
// Define ARA_JTAG_RUNTIME_CNT_EN to make runtime_buf_q count; otherwise it is tied to 0.
module ara_jtag_test_harness
    import ara_jtag_tb_pkg::*;
#(
    parameter int unsigned NrLanes      = 2,
    parameter int unsigned AxiAddrWidth = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [31:0] exit_o,
    input  logic        jtag_tck_i,
    input  logic        jtag_trst_ni,
    output logic        jtag_tdo_o,
    input  logic        jtag_tdi_i,
    input  logic        jtag_tms_i
);

    if (AxiAddrWidth != 32 && AxiAddrWidth != 64) begin : gen_bad_addr_width
        $fatal(1, "ara_jtag_test_harness: AxiAddrWidth must be 32 or 64");
    end

    localparam logic [31:0] InfoValue = {16'(AxiAddrWidth), 16'(NrLanes)};

    ara_jtag_test_harness_if jtag_if ();

    assign jtag_if.tck    = jtag_tck_i;
    assign jtag_if.trst_n = jtag_trst_ni;
    assign jtag_if.tms    = jtag_tms_i;
    assign jtag_if.tdi    = jtag_tdi_i;
    assign jtag_tdo_o     = jtag_if.tdo;

    logic        upd;
    logic [7:0]  upd_addr;
    memacc_op_e  upd_op;
    logic [31:0] upd_wdata;

    logic [31:0] exit_q, exit_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  status_q, status_d;
    logic [31:0] scratch_q [16];
    logic [31:0] scratch_d [16];
    logic [63:0] runtime_buf_q;
    logic [31:0] rd_val;
    logic        mapped, is_scratch;

    ara_jtag_tap u_tap (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .jtag     (jtag_if.slave),
        .update_o (upd),
        .addr_o   (upd_addr),
        .op_o     (upd_op),
        .wdata_o  (upd_wdata),
        .rdata_i  (rdata_q),
        .status_i (status_q)
    );

    always_comb begin
        exit_d     = exit_q;
        rdata_d    = rdata_q;
        status_d   = status_q;
        scratch_d  = scratch_q;
        rd_val     = '0;
        mapped     = 1'b1;
        is_scratch = (upd_addr[7:4] == ScratchPage);
        if (upd_addr == AddrTohost) begin
            rd_val = exit_q;
        end else if (upd_addr == AddrCyclesLo) begin
            rd_val = runtime_buf_q[31:0];
        end else if (upd_addr == AddrCyclesHi) begin
            rd_val = runtime_buf_q[63:32];
        end else if (upd_addr == AddrInfo) begin
            rd_val = InfoValue;
        end else if (is_scratch) begin
            rd_val = scratch_q[upd_addr[3:0]];
        end else begin
            mapped = 1'b0;
        end
        if (upd && (upd_op == OpRead || upd_op == OpWrite)) begin
            status_d = mapped ? StatusOk : StatusUnmapped;
            if (upd_op == OpRead) begin
                rdata_d = rd_val;
            end else begin
                // The first completed tohost write wins; later ones cannot mask a result.
                if (upd_addr == AddrTohost && !exit_q[0]) exit_d = upd_wdata;
                if (is_scratch) scratch_d[upd_addr[3:0]] = upd_wdata;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            exit_q    <= '0;
            rdata_q   <= '0;
            status_q  <= StatusOk;
            scratch_q <= '{default: '0};
        end else begin
            exit_q    <= exit_d;
            rdata_q   <= rdata_d;
            status_q  <= status_d;
            scratch_q <= scratch_d;
        end
    end

`ifdef ARA_JTAG_RUNTIME_CNT_EN
    logic [63:0] runtime_buf_d;

    always_comb begin
        runtime_buf_d = runtime_buf_q;
        if (!exit_q[0]) runtime_buf_d = runtime_buf_q + 64'd1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            runtime_buf_q <= '0;
        end else begin
            runtime_buf_q <= runtime_buf_d;
        end
    end
`else
    assign runtime_buf_q = '0;
`endif

    assign exit_o = exit_q;

endmodule

// File: tb/tb_ara_jtag_test_harness.sv
// Bench for ara_jtag_test_harness: JTAG driver tasks, a register-space reference model and a
// scoreboard monitor comparing every captured scan against the queued expectation.
module tb_ara_jtag_test_harness;

    localparam int unsigned HalfTck = 6;
`ifdef ARA_JTAG_RUNTIME_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [41:0] val;
        logic [41:0] mask;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] exit_w;

    ara_jtag_test_harness_if jtag ();

    always #5 clk = ~clk;

    ara_jtag_test_harness #(
        .NrLanes      (4),
        .AxiAddrWidth (64)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .exit_o       (exit_w),
        .jtag_tck_i   (jtag.tck),
        .jtag_trst_ni (jtag.trst_n),
        .jtag_tdo_o   (jtag.tdo),
        .jtag_tdi_i   (jtag.tdi),
        .jtag_tms_i   (jtag.tms)
    );

    exp_t        exp_q[$];
    logic [41:0] obs_q[$];
    logic [41:0] last_obs;
    int          n_vec = 0;
    int          n_bad = 0;

    // Reference model of the register space as seen through MEMACC.
    logic [31:0] m_scratch [16];
    logic [31:0] m_exit, m_rdata;
    logic [7:0]  m_last;
    logic [1:0]  m_status;
    logic        m_rdata_dc;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_scratch[i] = '0;
        m_exit = '0; m_rdata = '0; m_last = '0; m_status = '0; m_rdata_dc = 1'b0;
    endfunction

    function automatic void model_apply(input logic [7:0] a, input logic [1:0] op,
                                        input logic [31:0] d);
        int  ai;
        bit  scr, known;
        ai    = int'(a);
        scr   = (ai >= 16 && ai < 32);
        known = (ai <= 3) || scr;
        if (op != 2'd1 && op != 2'd2) return;
        m_last   = a;
        m_status = known ? 2'd0 : 2'd2;
        if (op == 2'd1) begin
            m_rdata_dc = 1'b0;
            if (ai == 0) m_rdata = m_exit;
            else if (ai == 1 || ai == 2) begin m_rdata = '0; m_rdata_dc = CntEn; end
            else if (ai == 3) m_rdata = {16'd64, 16'd4};
            else if (scr) m_rdata = m_scratch[ai-16];
            else m_rdata = '0;
        end else begin
            if (ai == 0 && !m_exit[0]) m_exit = d;
            if (scr) m_scratch[ai-16] = d;
        end
    endfunction

    task automatic check(input string tag, input logic [41:0] act, input logic [41:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic expect_scan(input string tag, input logic [41:0] val, input logic [41:0] mask);
        exp_t e;
        e.tag = tag; e.val = val; e.mask = mask;
        exp_q.push_back(e);
    endtask

    // One TCK period: inputs change with the falling edge, TDO sampled just before the rise.
    task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo);
        @(negedge clk);
        jtag.tck = 1'b0; jtag.tms = tms; jtag.tdi = tdi;
        repeat (HalfTck) @(negedge clk);
        tdo = jtag.tdo;
        jtag.tck = 1'b1;
        repeat (HalfTck - 1) @(negedge clk);
    endtask

    task automatic tms_only(input logic tms);
        logic unused_tdo;
        tck_cycle(tms, 1'b0, unused_tdo);
    endtask

    task automatic tap_reset();
        repeat (5) tms_only(1'b1);
        tms_only(1'b0);
    endtask

    // Full scan from Run-Test/Idle back to Run-Test/Idle; captured bits go to the monitor.
    task automatic scan(input logic is_ir, input int n, input logic [41:0] din);
        logic [41:0] dout;
        logic        b;
        dout = '0;
        tms_only(1'b1);
        if (is_ir) tms_only(1'b1);
        tms_only(1'b0);
        tms_only(1'b0);
        for (int i = 0; i < n; i++) begin
            tck_cycle(i == n - 1, din[i], b);
            dout[i] = b;
        end
        tms_only(1'b1);
        tms_only(1'b0);
        last_obs = dout;
        obs_q.push_back(dout);
    endtask

    task automatic memacc(input logic [7:0] a, input logic [1:0] op, input logic [31:0] d,
                          input string tag);
        logic [41:0] mask;
        mask = '1;
        if (m_rdata_dc) mask[33:2] = '0;
        expect_scan(tag, {m_last, m_rdata, m_status}, mask);
        scan(1'b0, 42, {a, d, op});
        model_apply(a, op, d);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [41:0] o;
        forever begin
            @(posedge clk);
            while (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_scan: got %h, expected no scan", o);
                end else begin
                    e = exp_q.pop_front();
                    if ((o & e.mask) !== (e.val & e.mask)) begin
                        n_bad++;
                        $display("FAIL %s: got %h, expected %h (mask %h)", e.tag, o, e.val,
                                 e.mask);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got no end of test, expected finish within 90000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [7:0]  a;
        logic [41:0] pd;
        logic        b;
        int          sel;
`ifdef ARA_JTAG_RUNTIME_CNT_EN
        logic [31:0] cyc_a;
        logic [31:0] cyc_b;
`endif
        jtag.tck = 1'b0; jtag.tms = 1'b1; jtag.tdi = 1'b0; jtag.trst_n = 1'b1;
        rst_n = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        check("reset_exit", 42'(exit_w), 42'(m_exit));
        check("reset_tdo", 42'(jtag.tdo), 42'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        tap_reset();
        expect_scan("idcode", 42'h0_1A4A_0DB3, '1);
        scan(1'b0, 32, '0);

        expect_scan("ir_capture_bypass", 42'b00001, '1);
        scan(1'b1, 5, 42'h1F);
        expect_scan("bypass_a5", 42'h14A, '1);
        scan(1'b0, 9, 42'h0A5);

        expect_scan("ir_capture_memacc", 42'b00001, '1);
        scan(1'b1, 5, 42'h10);
        memacc(8'h13, 2'd2, 32'hDEAD_BEEF, "wr_scratch13");
        memacc(8'h13, 2'd1, 32'h0, "rd_scratch13");
        memacc(8'h40, 2'd1, 32'h0, "rd_unmapped40");
        memacc(8'h03, 2'd1, 32'h5555_AAAA, "rd_info");
        memacc(8'h01, 2'd1, 32'h0, "rd_cycles_lo");
        memacc(8'h02, 2'd1, 32'h0, "rd_cycles_hi");

        for (int i = 0; i < 16; i++) begin
            sel = int'($urandom_range(9));
            if (sel <= 5) a = 8'h10 + 8'($urandom_range(15));
            else if (sel <= 7) a = 8'($urandom_range(255, 32));
            else a = 8'($urandom_range(3, 1));
            memacc(a, 2'($urandom_range(2, 1)), $urandom, "random_op");
        end

        memacc(8'h00, 2'd2, 32'h1, "wr_tohost_pass");
        check("exit_pass", 42'(exit_w), 42'(m_exit));
        memacc(8'h01, 2'd1, 32'h0, "rd_cycles_frozen_a");
        memacc(8'h01, 2'd1, 32'h0, "rd_cycles_frozen_b");
`ifdef ARA_JTAG_RUNTIME_CNT_EN
        cyc_a = last_obs[33:2];
`endif
        memacc(8'h00, 2'd2, 32'h7, "wr_tohost_late");
`ifdef ARA_JTAG_RUNTIME_CNT_EN
        cyc_b = last_obs[33:2];
        check("cycles_frozen", 42'(cyc_b), 42'(cyc_a));
        check("cycles_vs_buf", 42'(cyc_b), 42'(dut.runtime_buf_q[31:0]));
`endif
        check("exit_sticky", 42'(exit_w), 42'(m_exit));
        memacc(8'h00, 2'd1, 32'h0, "rd_tohost");
        memacc(8'h03, 2'd1, 32'h0, "rd_info_flush");

        // TAP-only reset: register space must survive.
        jtag.trst_n = 1'b0;
        repeat (8) @(negedge clk);
        jtag.trst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("trst_keeps_exit", 42'(exit_w), 42'(m_exit));
        tms_only(1'b0);
        expect_scan("idcode_after_trst", 42'h0_1A4A_0DB3, '1);
        scan(1'b0, 32, '0);
        expect_scan("ir_capture_trst", 42'b00001, '1);
        scan(1'b1, 5, 42'h10);
        memacc(8'h13, 2'd1, 32'h0, "rd_scratch13_trst");
        memacc(8'h03, 2'd1, 32'h0, "flush_trst");

        // System reset in the middle of shifting a scratch write.
        pd = {8'h15, 32'hCAFE_F00D, 2'd2};
        tms_only(1'b1);
        tms_only(1'b0);
        tms_only(1'b0);
        for (int i = 0; i < 20; i++) tck_cycle(1'b0, pd[i], b);
        @(negedge clk);
        jtag.tck = 1'b0;
        repeat (HalfTck) @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        check("midshift_reset_exit", 42'(exit_w), 42'(m_exit));
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        tms_only(1'b0);
        expect_scan("idcode_after_rst", 42'h0_1A4A_0DB3, '1);
        scan(1'b0, 32, '0);
        expect_scan("ir_capture_rst", 42'b00001, '1);
        scan(1'b1, 5, 42'h10);
        memacc(8'h15, 2'd1, 32'h0, "rd_scratch15_after_rst");
        memacc(8'h00, 2'd2, 32'h7, "wr_tohost_fail3");
        memacc(8'h03, 2'd1, 32'h0, "flush_fail");
        check("exit_fail", 42'(exit_w), 42'(m_exit));
        check("fail_code", 42'(exit_w[31:1]), 42'd3);
        check("fail_done", 42'(exit_w[0]), 42'd1);

        repeat (20) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scan_count: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
